// File: rtl/instr_fetch_mem_pkg.sv
// Shared definitions for the instruction fetch memory.
//   - Fault codes reported with each fetch response.
//   - FSM state encoding (CLEAR sweeps the array to zero, RUN serves fetches).
//   - Response record {instr, fault} in the default 32-bit instruction width;
//     the queue payload is packed in this same field order at any width.
package instr_fetch_mem_pkg;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RESP_INSTR_W = 32;

  typedef struct packed {
    logic [RESP_INSTR_W-1:0] instr;
    logic [1:0]              fault;
  } resp_t;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Bus bundle for the instruction fetch memory.
//   master: fetch-stage side (drives program port, requests, resp_ready)
//   slave : the memory (drives init_done, req_ready and the response)
//
// Handshake rule for both req_* and resp_*: a transfer happens on a rising
// edge where valid && ready are both high. The sender holds valid and its
// payload stable until the transfer; ready may depend combinationally on the
// other side (req_ready depends on resp_ready through the queue pop).
interface instr_fetch_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 6,
  parameter int DEPTH  = 128
);
  localparam int AW = $clog2(DEPTH);

  logic              init_done;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_instr;
  logic [OPC_W-1:0]  resp_opcode;
  logic [1:0]        resp_fault;

  modport master (
    input  init_done, req_ready, resp_valid, resp_instr, resp_opcode, resp_fault,
    output prog_we, prog_addr, prog_data, req_valid, req_addr, resp_ready
  );

  modport slave (
    output init_done, req_ready, resp_valid, resp_instr, resp_opcode, resp_fault,
    input  prog_we, prog_addr, prog_data, req_valid, req_addr, resp_ready
  );

endinterface

// File: rtl/instr_fetch_mem_resp_fifo.sv
// Small synchronous FIFO used as the fetch response queue.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full unless popping)
//   push_data  : entry to enqueue
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   count      : number of stored entries
//   empty      : count == 0
// A push and a pop in the same cycle leave the count unchanged, so a full
// FIFO can be drained and refilled on one edge (this also covers DEPTH=1).
module instr_fetch_mem_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory for the fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_mem_if.slave
//                  init_done            - array clear finished, fetches allowed
//                  prog_we/addr/data    - program-load write port (RUN only)
//                  req_valid/ready/addr - byte-addressed fetch request
//                  resp_valid/ready     - head of the response queue
//                  resp_instr/opcode/fault - head response payload
//   dbg_state  : current FSM state
// After reset the FSM sweeps every word to zero (DEPTH cycles), then serves
// fetches. The array read result is captured straight into the response
// queue tail on the accepting edge, so nothing is ever in flight between
// edges and the response is visible one cycle after acceptance.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 32,
  parameter int OUT_DEPTH = 2,
  parameter int OPC_W     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_mem_if.slave    bus,
  output state_e              dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int RW = DATA_W + 2;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        req_fault;
  logic [DATA_W-1:0] req_instr;
  logic              accept;
  logic              pop;
  logic              has_room;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [RW-1:0]     head;

  // FSM and single write port: CLEAR owns the port, RUN gives it to prog_we.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.prog_addr;
    mem_wdata = bus.prog_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = bus.prog_we;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Misalignment wins over range; the range test uses the full word
  // address so high address bits can never alias onto a valid word.
  assign word_addr = bus.req_addr >> 2;

  always_comb begin
    req_fault = FAULT_OK;
    if (bus.req_addr[1:0] != 2'b00) begin
      req_fault = FAULT_MISALIGN;
    end else if (word_addr >= ADDR_W'(DEPTH)) begin
      req_fault = FAULT_RANGE;
    end
  end

  assign req_instr = (req_fault == FAULT_OK) ? mem[word_addr[AW-1:0]] : '0;

  // A pop on this edge frees a slot, so a full queue can still accept:
  // this is the intended resp_ready -> req_ready combinational path.
  assign pop           = !fifo_empty && bus.resp_ready;
  assign has_room      = (fifo_count < CW'(OUT_DEPTH)) || pop;
  assign bus.req_ready = (state_q == ST_RUN) && !bus.prog_we && has_room;
  assign accept        = bus.req_valid && bus.req_ready;

  instr_fetch_mem_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (OUT_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({req_instr, req_fault}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.resp_valid  = !fifo_empty;
  assign bus.resp_instr  = head[RW-1:2];
  assign bus.resp_fault  = head[1:0];
  assign bus.resp_opcode = head[RW-1 -: OPC_W];
  assign bus.init_done   = (state_q == ST_RUN);
  assign dbg_state       = state_q;

endmodule
